// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and constants for the stopwatch timebase
package stopwatch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, STOP, LAP} sw_state_t;

  localparam int DEFAULT_MAX_COUNT = 5999;
  localparam int COUNT_W           = 16;

  function automatic logic [COUNT_W-1:0] wrap_inc(input logic [COUNT_W-1:0] v,
                                                  input logic [COUNT_W-1:0] max_v);
    return (v == max_v) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/stopwatch_counter_tick_gen.sv
// rtl/stopwatch_counter_tick_gen.sv - prescaler producing one-cycle ticks every DIV enabled clocks
module tick_gen #(
  parameter int DIV = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;

  // Holding the count while disabled lets a paused stopwatch keep its fractional interval.
  always_comb begin
    tick  = en && (pre_q == LAST);
    pre_d = pre_q;
    if (clr) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// rtl/stopwatch_counter.sv - button edge detect, run/stop/lap FSM and centisecond elapsed count
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 100,
  parameter int MAX_COUNT   = DEFAULT_MAX_COUNT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_start,
  input  logic               btn_clear,
  input  logic               btn_lap,
  output logic [COUNT_W-1:0] count,
  output logic               running,
  output logic               lap_active
);

  localparam int                 DIV   = CLK_FREQ_HZ / TICK_HZ;
  localparam logic [COUNT_W-1:0] MAX_C = COUNT_W'(MAX_COUNT);

  sw_state_t          state_q, state_d;
  logic [COUNT_W-1:0] elapsed_q, elapsed_d;
  logic [COUNT_W-1:0] lap_val_q, lap_val_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               running_q, running_d;
  logic               lap_active_q, lap_active_d;
  logic               btn_start_q, btn_clear_q, btn_lap_q;
  logic               armed_q, armed_d;

  logic press_start, press_clear, press_lap;
  logic presc_en, presc_clr, tick;

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (presc_en),
    .clr  (presc_clr),
    .tick (tick)
  );

  // armed_q masks the first clock after reset, so a button already down at release is not a press.
  always_comb begin
    armed_d     = 1'b1;
    press_start = armed_q & btn_start & ~btn_start_q;
    press_clear = armed_q & btn_clear & ~btn_clear_q;
    press_lap   = armed_q & btn_lap & ~btn_lap_q;
    presc_en    = (state_q == RUN) || (state_q == LAP);
  end

  always_comb begin
    state_d   = state_q;
    elapsed_d = elapsed_q;
    lap_val_d = lap_val_q;
    presc_clr = 1'b0;

    if (tick) begin
      elapsed_d = wrap_inc(elapsed_q, MAX_C);
    end

    // Clear outranks start, start outranks lap; presses invalid in a state are dropped.
    unique case (state_q)
      IDLE: begin
        if (press_clear) begin
          presc_clr = 1'b1;
        end else if (press_start) begin
          state_d   = RUN;
          presc_clr = 1'b1;
        end
      end
      RUN: begin
        if (press_start) begin
          state_d = STOP;
        end else if (press_lap) begin
          state_d   = LAP;
          lap_val_d = elapsed_q;
        end
      end
      LAP: begin
        if (press_start) begin
          state_d = STOP;
        end else if (press_lap) begin
          state_d = RUN;
        end
      end
      STOP: begin
        if (press_clear) begin
          state_d   = IDLE;
          elapsed_d = '0;
          presc_clr = 1'b1;
        end else if (press_start) begin
          state_d = RUN;
        end
      end
    endcase
  end

  always_comb begin
    count_d      = (state_q == LAP) ? lap_val_q : elapsed_q;
    running_d    = (state_q == RUN) || (state_q == LAP);
    lap_active_d = (state_q == LAP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      elapsed_q    <= '0;
      lap_val_q    <= '0;
      count_q      <= '0;
      running_q    <= 1'b0;
      lap_active_q <= 1'b0;
      btn_start_q  <= 1'b0;
      btn_clear_q  <= 1'b0;
      btn_lap_q    <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      elapsed_q    <= elapsed_d;
      lap_val_q    <= lap_val_d;
      count_q      <= count_d;
      running_q    <= running_d;
      lap_active_q <= lap_active_d;
      btn_start_q  <= btn_start;
      btn_clear_q  <= btn_clear;
      btn_lap_q    <= btn_lap;
      armed_q      <= armed_d;
    end
  end

  assign count      = count_q;
  assign running    = running_q;
  assign lap_active = lap_active_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// tb/tb_stopwatch_counter.sv - directed self-checking bench for stopwatch_counter with DIV=10
module tb_stopwatch_counter;
  import stopwatch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_start = 1'b0;
  logic        btn_clear = 1'b0;
  logic        btn_lap = 1'b0;
  logic [15:0] count;
  logic        running;
  logic        lap_active;

  int checks = 0;
  int errors = 0;
  int max_seen = 0;

  stopwatch_counter #(
    .CLK_FREQ_HZ (1000),
    .TICK_HZ     (100),
    .MAX_COUNT   (5999)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_start  (btn_start),
    .btn_clear  (btn_clear),
    .btn_lap    (btn_lap),
    .count      (count),
    .running    (running),
    .lap_active (lap_active)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (int'(count) > max_seen) max_seen = int'(count);

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    btn_start = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic wait_count(input int target, input int bound, output bit found);
    found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk);
      if (int'(count) == target) found = 1'b1;
    end
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %0b expected 0", running); end
    checks++; if (lap_active !== 1'b0) begin errors++; $display("FAIL reset_lap_active: got %0b expected 0", lap_active); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE); end
  endtask

  task automatic test_count_rate;
    logic [15:0] exp;
    do_reset();
    btn_start = 1'b1; cyc(1); btn_start = 1'b0;
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL rate_running_press_edge: got %0b expected 0", running); end
    cyc(1);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL rate_running_after: got %0b expected 1", running); end
    checks++; if (count !== 16'd0) begin errors++; $display("FAIL rate_count_start: got %0d expected 0", count); end
    for (int k = 2; k <= 101; k++) begin
      cyc(1);
      exp = 16'((k - 1) / 10);
      checks++;
      if (count !== exp) begin errors++; $display("FAIL rate_count_cycle%0d: got %0d expected %0d", k, count, exp); end
    end
  endtask

  task automatic test_wrap;
    bit found;
    do_reset();
    btn_start = 1'b1; cyc(1); btn_start = 1'b0;
    wait_count(5998, 61000, found);
    checks++; if (!found) begin errors++; $display("FAIL wrap_reach_5998: got count %0d expected 5998 within bound", count); end
    cyc(10);
    checks++; if (count !== 16'd5999) begin errors++; $display("FAIL wrap_max: got %0d expected 5999", count); end
    cyc(10);
    checks++; if (count !== 16'd0) begin errors++; $display("FAIL wrap_zero: got %0d expected 0", count); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL wrap_running: got %0b expected 1", running); end
    checks++; if (max_seen > 5999) begin errors++; $display("FAIL wrap_max_seen: got %0d expected <= 5999", max_seen); end
  endtask

  task automatic test_lap;
    bit found;
    do_reset();
    btn_start = 1'b1; cyc(1); btn_start = 1'b0;
    wait_count(42, 600, found);
    checks++; if (!found) begin errors++; $display("FAIL lap_reach_42: got count %0d expected 42 within bound", count); end
    btn_lap = 1'b1; cyc(1); btn_lap = 1'b0;
    cyc(1);
    checks++; if (lap_active !== 1'b1) begin errors++; $display("FAIL lap_active_set: got %0b expected 1", lap_active); end
    checks++; if (count !== 16'd42) begin errors++; $display("FAIL lap_freeze_start: got %0d expected 42", count); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL lap_running: got %0b expected 1", running); end
    cyc(49);
    checks++; if (count !== 16'd42) begin errors++; $display("FAIL lap_freeze_hold: got %0d expected 42", count); end
    btn_lap = 1'b1; cyc(1); btn_lap = 1'b0;
    cyc(1);
    checks++; if (count !== 16'd47) begin errors++; $display("FAIL lap_release_jump: got %0d expected 47", count); end
    checks++; if (lap_active !== 1'b0) begin errors++; $display("FAIL lap_active_clear: got %0b expected 0", lap_active); end
    cyc(7);
    checks++; if (count !== 16'd48) begin errors++; $display("FAIL lap_live_track: got %0d expected 48", count); end
    // lap press lands on the tick edge: frozen value is the pre-increment count
    cyc(8);
    btn_lap = 1'b1; cyc(1); btn_lap = 1'b0;
    cyc(1);
    checks++; if (count !== 16'd48) begin errors++; $display("FAIL lap_on_tick: got %0d expected 48", count); end
    checks++; if (lap_active !== 1'b1) begin errors++; $display("FAIL lap_on_tick_active: got %0b expected 1", lap_active); end
  endtask

  task automatic test_stop_resume_clear;
    do_reset();
    btn_start = 1'b1; cyc(1); btn_start = 1'b0;
    cyc(16);
    btn_start = 1'b1; cyc(1); btn_start = 1'b0;
    cyc(1);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL stop_running: got %0b expected 0", running); end
    checks++; if (count !== 16'd1) begin errors++; $display("FAIL stop_count: got %0d expected 1", count); end
    cyc(1000);
    checks++; if (count !== 16'd1) begin errors++; $display("FAIL stop_hold_count: got %0d expected 1", count); end
    btn_start = 1'b1; cyc(1); btn_start = 1'b0;
    cyc(1);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL resume_running: got %0b expected 1", running); end
    cyc(2);
    checks++; if (count !== 16'd1) begin errors++; $display("FAIL resume_before_tick: got %0d expected 1", count); end
    cyc(1);
    checks++; if (count !== 16'd2) begin errors++; $display("FAIL resume_tick_after_3: got %0d expected 2", count); end
    btn_clear = 1'b1; cyc(1); btn_clear = 1'b0;
    cyc(1);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL clear_in_run_running: got %0b expected 1", running); end
    checks++; if (count !== 16'd2) begin errors++; $display("FAIL clear_in_run_count: got %0d expected 2", count); end
    btn_start = 1'b1; cyc(1); btn_start = 1'b0;
    cyc(1);
    checks++; if (count !== 16'd2) begin errors++; $display("FAIL stop2_count: got %0d expected 2", count); end
    btn_clear = 1'b1; cyc(1); btn_clear = 1'b0;
    cyc(1);
    checks++; if (count !== 16'd0) begin errors++; $display("FAIL clear_count: got %0d expected 0", count); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL clear_running: got %0b expected 0", running); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL clear_state: got %0d expected %0d", dut.state_q, IDLE); end
    // restart after clear must see a full ten-cycle interval
    btn_start = 1'b1; cyc(1); btn_start = 1'b0;
    cyc(10);
    checks++; if (count !== 16'd0) begin errors++; $display("FAIL restart_no_early_tick: got %0d expected 0", count); end
    cyc(1);
    checks++; if (count !== 16'd1) begin errors++; $display("FAIL restart_first_tick: got %0d expected 1", count); end
  endtask

  task automatic test_priority_hold;
    int run_seen;
    do_reset();
    btn_start = 1'b1; cyc(1); btn_start = 1'b0;
    cyc(25);
    btn_start = 1'b1; cyc(1); btn_start = 1'b0;
    cyc(1);
    checks++; if (count !== 16'd2) begin errors++; $display("FAIL prio_stop_count: got %0d expected 2", count); end
    btn_start = 1'b1; btn_clear = 1'b1;
    run_seen = 0;
    for (int i = 0; i < 500; i++) begin
      cyc(1);
      if (running !== 1'b0) run_seen++;
    end
    checks++; if (run_seen != 0) begin errors++; $display("FAIL prio_running_during_hold: got %0d cycles expected 0", run_seen); end
    checks++; if (count !== 16'd0) begin errors++; $display("FAIL prio_clear_count: got %0d expected 0", count); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL prio_state: got %0d expected %0d", dut.state_q, IDLE); end
    btn_start = 1'b0; btn_clear = 1'b0;
    cyc(1);
    btn_start = 1'b1;
    cyc(500);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL hold_start_running: got %0b expected 1", running); end
    checks++; if (count !== 16'd49) begin errors++; $display("FAIL hold_start_count: got %0d expected 49", count); end
    btn_start = 1'b0;
    cyc(1);
  endtask

  task automatic test_async_reset;
    bit found;
    do_reset();
    btn_start = 1'b1; cyc(1); btn_start = 1'b0;
    wait_count(300, 3200, found);
    checks++; if (!found) begin errors++; $display("FAIL areset_reach_300: got count %0d expected 300 within bound", count); end
    btn_lap = 1'b1; cyc(1); btn_lap = 1'b0;
    cyc(3);
    checks++; if (lap_active !== 1'b1) begin errors++; $display("FAIL areset_in_lap: got %0b expected 1", lap_active); end
    checks++; if (count !== 16'd300) begin errors++; $display("FAIL areset_lap_count: got %0d expected 300", count); end
    #2;
    rst = 1'b1;
    btn_start = 1'b1;
    #1;
    checks++; if (count !== 16'd0) begin errors++; $display("FAIL areset_count: got %0d expected 0", count); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL areset_running: got %0b expected 0", running); end
    checks++; if (lap_active !== 1'b0) begin errors++; $display("FAIL areset_lap_active: got %0b expected 0", lap_active); end
    @(negedge clk);
    rst = 1'b0;
    cyc(5);
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL areset_held_btn_state: got %0d expected %0d", dut.state_q, IDLE); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL areset_held_btn_running: got %0b expected 0", running); end
    btn_start = 1'b0; cyc(1);
    btn_start = 1'b1; cyc(1); btn_start = 1'b0;
    cyc(1);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL areset_repress_running: got %0b expected 1", running); end
  endtask

  initial begin
    test_reset();
    test_count_rate();
    test_wrap();
    test_lap();
    test_stop_resume_clear();
    test_priority_hold();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
